// File: rtl/load_store_unit.sv
// Load/store controller for a byte-addressed, little-endian, 32-bit data memory.
// Accepts one request at a time, sequences MemRead/MemWrite, extends sub-word
// loads, and performs sub-word stores as read-modify-write.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               rd_last;

  // Alignment and opcode legality; unsigned variants are meaningless for stores.
  function automatic logic req_bad(input logic we, input logic [2:0] op,
                                   input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (op)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = |a;
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Load extraction from the low lanes of the returned word.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                  input logic [2:0] op);
    logic [DATA_W-1:0] r;
    r = d;
    case (op[1:0])
      2'b00:   r = op[2] ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   r = op[2] ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Sub-word store merge: replace the low byte/half, keep upper bytes.
  function automatic logic [DATA_W-1:0] st_merge(input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [2:0] op);
    return op[0] ? {old[31:16], wd[15:0]} : {old[31:8], wd[7:0]};
  endfunction

  assign rd_last = (wait_cnt_q == CNT_W'(WAIT_CYCLES));

  // Strobes and handshake decoded straight from the state register.
  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == RD);
  assign mem_write  = (state_q == WR);
  assign resp_valid = (state_q == DONE);
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      wait_cnt_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state and datapath update; write data is only non-zero while in WR.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wait_cnt_d   = wait_cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.we     = req_we;
          req_d.op     = req_op;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          wait_cnt_d   = '0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (req_bad(req_we, req_op, req_addr[1:0])) begin
            resp_err_d = 1'b1;
            state_d    = DONE;
          end else if (req_we && (req_op == 3'b010)) begin
            mem_wdata_d = req_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (rd_last) begin
          if (req_q.we) begin
            mem_wdata_d = st_merge(mem_rdata, req_q.wdata, req_q.op);
            state_d     = WR;
          end else begin
            resp_rdata_d = load_ext(mem_rdata, req_q.op);
            state_d      = DONE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (WAIT_CYCLES 0 and 2), each with a
// 32-byte memory returning/writing the 4 bytes starting at Address (mod 32).
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_err, mem_read, mem_write;
  logic [2:0]  req_op     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  logic        mem_load;
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          n;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          rd_cnt [2];
  int          wr_cnt [2];
  logic [31:0] wd_seen [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [32];
    logic [4:0] ma;

    load_store_unit #(.WAIT_CYCLES(g * 2), .ADDR_W(32)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_op     (req_op[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .mem_read   (mem_read[g]),
      .mem_write  (mem_write[g])
    );

    assign ma = mem_addr[g][4:0];
    assign mem_rdata[g] = {mem[5'(ma + 5'd3)], mem[5'(ma + 5'd2)],
                           mem[5'(ma + 5'd1)], mem[ma]};

    always @(posedge clk) begin
      if (mem_load) begin
        for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      end else if (mem_write[g]) begin
        for (int k = 0; k < 4; k++) mem[5'(ma + 5'(k))] <= mem_wdata[g][8*k +: 8];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Monitor: strobe rules every cycle, scoreboard pop on each response pulse.
  initial begin
    exp_t e;
    logic orphan;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int d = 0; d < 2; d++) begin
          rd_cnt[d]  = 0;
          wr_cnt[d]  = 0;
          wd_seen[d] = '0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          check32("strobe_overlap", d, 32'(mem_read[d] & mem_write[d]), 32'h0);
          if (!mem_write[d]) check32("wdata_idle", d, mem_wdata[d], 32'h0);
          orphan = (mem_read[d] | mem_write[d] | resp_valid[d]) &&
                   ((q.size() == 0) || (q[0].d != d));
          check32("orphan_activity", d, 32'(orphan), 32'h0);
          if (!orphan) begin
            if (mem_read[d] || mem_write[d]) check32("mem_addr", d, mem_addr[d], q[0].addr);
            if (mem_read[d]) rd_cnt[d]++;
            if (mem_write[d]) begin
              wr_cnt[d]++;
              wd_seen[d] = mem_wdata[d];
            end
            if (resp_valid[d]) begin
              e = q.pop_front();
              check32("resp_rdata", d, resp_rdata[d], e.rdata);
              check32("resp_err", d, 32'(resp_err[d]), 32'(e.err));
              check32("resp_latency", d, 32'(cyc - e.n), 32'(e.lat));
              check32("read_cycles", d, 32'(rd_cnt[d]), 32'(e.rd));
              check32("write_cycles", d, 32'(wr_cnt[d]), 32'(e.wr));
              if (e.wr != 0) check32("write_data", d, wd_seen[d], e.wdata);
              rd_cnt[d]  = 0;
              wr_cnt[d]  = 0;
              wd_seen[d] = '0;
            end
          end
        end
      end
    end
  end

  // Issue one request; req_valid stays high while busy to show it is ignored.
  task automatic issue(input int d, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input int rd, input int wr,
                       input logic [31:0] exp_wdata);
    exp_t e;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_op[d]    = op;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
    check32("accept_ready", d, 32'(req_ready[d]), 32'h1);
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      return;
    end
    e.d = d; e.addr = addr; e.rdata = exp_rdata; e.err = exp_err; e.n = cyc;
    e.lat = lat; e.rd = rd; e.wr = wr; e.wdata = exp_wdata;
    q.push_back(e);
    @(posedge clk);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check32("busy_ready", d, 32'(req_ready[d]), 32'h0);
    end
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b0;
    req_op[d]    = 3'b000;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check32("resp_pending", d, 32'(q.size()), 32'h0);
    q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    mem_load  = 1'b1;
    req_valid = '0;
    req_we    = '0;
    for (int d = 0; d < 2; d++) begin
      req_op[d]    = 3'b000;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check32("rst_ready", d, 32'(req_ready[d]), 32'h1);
      check32("rst_strobes", d, {29'h0, mem_read[d], mem_write[d], resp_valid[d]}, 32'h0);
      check32("rst_rdata", d, resp_rdata[d], 32'h0);
      check32("rst_err", d, 32'(resp_err[d]), 32'h0);
      check32("rst_addr", d, mem_addr[d], 32'h0);
      check32("rst_wdata", d, mem_wdata[d], 32'h0);
    end
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    reset_n  = 1'b1;

    // WAIT_CYCLES = 0 instance
    issue(0, 1'b0, 3'b010, 32'd4,  32'h0,        32'h07060504, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b1, 3'b010, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF);
    issue(0, 1'b0, 3'b000, 32'd8,  32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b0, 3'b100, 32'd8,  32'h0,        32'h000000EF, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b0, 3'b001, 32'd10, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b0, 3'b101, 32'd10, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b1, 3'b000, 32'd13, 32'hFFFFFFAA, 32'h0,        1'b0, 3, 1, 1, 32'h100F0EAA);
    issue(0, 1'b0, 3'b010, 32'd12, 32'h0,        32'h0F0EAA0C, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b1, 3'b001, 32'd20, 32'h1234CAFE, 32'h0,        1'b0, 3, 1, 1, 32'h1716CAFE);
    issue(0, 1'b0, 3'b010, 32'd20, 32'h0,        32'h1716CAFE, 1'b0, 2, 1, 0, 32'h0);
    issue(0, 1'b0, 3'b001, 32'd22, 32'h0,        32'h00001716, 1'b0, 2, 1, 0, 32'h0);
    // error paths: no strobes, response one cycle after acceptance
    issue(0, 1'b0, 3'b010, 32'd6,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    issue(0, 1'b1, 3'b001, 32'd3,  32'h5555,     32'h0,        1'b1, 1, 0, 0, 32'h0);
    issue(0, 1'b0, 3'b011, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    issue(0, 1'b1, 3'b100, 32'd0,  32'h11,       32'h0,        1'b1, 1, 0, 0, 32'h0);
    issue(0, 1'b0, 3'b111, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
    // error clears on the next good request
    issue(0, 1'b0, 3'b100, 32'd1,  32'h0,        32'h00000001, 1'b0, 2, 1, 0, 32'h0);

    // WAIT_CYCLES = 2 instance
    issue(1, 1'b0, 3'b010, 32'd0,  32'h0,        32'h03020100, 1'b0, 4, 3, 0, 32'h0);
    issue(1, 1'b0, 3'b000, 32'd31, 32'h0,        32'h0000001F, 1'b0, 4, 3, 0, 32'h0);
    issue(1, 1'b1, 3'b000, 32'd5,  32'h00000080, 32'h0,        1'b0, 5, 3, 1, 32'h08070680);
    issue(1, 1'b0, 3'b000, 32'd5,  32'h0,        32'hFFFFFF80, 1'b0, 4, 3, 0, 32'h0);

    // Reset during the RD of a store half: abandoned, no write, no response
    begin
      exp_t e;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_op[0]    = 3'b001;
      req_addr[0]  = 32'd16;
      req_wdata[0] = 32'h0000BEEF;
      e.d = 0; e.addr = 32'd16; e.rdata = '0; e.err = 1'b0; e.n = cyc;
      e.lat = 3; e.rd = 1; e.wr = 1; e.wdata = 32'h0;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      check32("abort_in_rd", 0, 32'(mem_read[0]), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      q.delete();
      check32("abort_ready", 0, 32'(req_ready[0]), 32'h1);
      check32("abort_strobes", 0, {29'h0, mem_read[0], mem_write[0], resp_valid[0]}, 32'h0);
      check32("abort_addr", 0, mem_addr[0], 32'h0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check32("rst_hold_strobes", 0, {29'h0, mem_read[0], mem_write[0], resp_valid[0]}, 32'h0);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    issue(0, 1'b0, 3'b010, 32'd16, 32'h0,        32'h13121110, 1'b0, 2, 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller that drives the byte-addressed, little-endian, 32-bit data memory interface (Address, WriteData, ReadData, MemRead, MemWrite) on behalf of the pipeline.
- Accepts one load/store request at a time over a valid/ready handshake and sequences the memory strobes.
- Performs byte/halfword extraction with sign or zero extension.
- Implements sub-word stores as read-modify-write, because the memory only writes 4 bytes at once.

Parameters:
- WAIT_CYCLES, 0, extra cycles mem_read is held before mem_rdata is sampled (memory access latency).
- ADDR_W, 32, width of req_addr and mem_addr.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; others are invalid.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or invalid op.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  32  to memory WriteData.
- mem_rdata  in  32  from memory ReadData.
- mem_read  out  1  to MemRead.
- mem_write  out  1  to MemWrite.

Behaviour:
- States: IDLE, RD, WR, DONE. A request is accepted on the edge where req_valid & req_ready; call that cycle N. On acceptance, req_we, req_op, req_addr and req_wdata are latched.
- req_ready = (state==IDLE). mem_read = (state==RD). mem_write = (state==WR). resp_valid = (state==DONE). All are decoded from state.
- During reset: state=IDLE, so req_ready=1 and all other strobes are 0. resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, and the latched request is cleared.
- Validation at acceptance:
  - half ops need addr[0]==0.
  - word ops need addr[1:0]==00.
  - ops 011/110/111 are invalid; for stores, op 100/101 is also invalid.
  - Any failure: next state is DONE with resp_err=1 and resp_rdata=0. No memory strobe is ever asserted. resp_valid is high in cycle N+1.
- Load:
  - RD for WAIT_CYCLES+1 cycles (N+1 .. N+1+WAIT_CYCLES), with mem_addr = latched addr.
  - mem_rdata is captured on the last RD cycle.
  - DONE is the following cycle, so resp_valid is at N+2+WAIT_CYCLES.
  - Extraction: byte uses bits 7:0, half uses bits 15:0. Signed ops replicate the top bit; unsigned ops zero-fill. Word passes through.
- Store word: WR in cycle N+1 with mem_wdata = req_wdata, then DONE at N+2. No read is issued.
- Store byte/half (read-modify-write):
  - RD as for a load.
  - WR for one cycle, with mem_wdata = captured word with bits 7:0 (byte) or 15:0 (half) replaced by req_wdata low bits. Upper bytes are written back unchanged.
  - DONE follows, so resp_valid is at N+3+WAIT_CYCLES.
- Strobe rules:
  - mem_read and mem_write are never high together.
  - mem_write is high for exactly one cycle per store, with mem_addr and mem_wdata stable throughout that cycle.
  - mem_wdata is 0 outside WR.
  - mem_addr holds the latched address from acceptance until the next acceptance.
- Output holding: resp_rdata and resp_err are registered and hold until the next acceptance, where they are cleared.
- DONE always returns to IDLE next cycle.
- A new request can be accepted in the cycle after DONE; no back-to-back acceptance inside DONE.
- While busy, req_valid is ignored; the requester holds the request until req_ready.
- Address wrap: handled by the memory (modulo its size); this unit does no wrap logic.
- Reset asserted mid-operation: immediate return to IDLE. Strobes drop asynchronously, no resp_valid is produced, and any partially completed RMW is abandoned without a write.

Test Plan:
- Bench memory: 32 bytes, byte i = i. Load word, WAIT_CYCLES=0, addr 4 -> mem_read high only at N+1; resp_valid at N+2; resp_rdata=0x07060504; resp_err=0.
- Extension:
  - Store word 0xDEADBEEF at 8, then load byte at 8 -> 0xFFFFFFEF.
  - Load byte unsigned at 8 -> 0x000000EF.
  - Load half at 10 -> 0xFFFFDEAD.
  - Load half unsigned at 10 -> 0x0000DEAD.
- Store byte 0xAA at addr 13:
  - Expect RD at N+1, then WR at N+2 with mem_wdata=0x100F0EAA, then resp_valid at N+3.
  - Follow-up load word at 12 -> 0x0F0EAA0C.
- Error path:
  - Load word at 6 -> resp_err=1, resp_rdata=0, resp_valid at N+1, no mem_read/mem_write.
  - Store half at 3 -> error.
  - op 011 -> error.
- WAIT_CYCLES=2:
  - Load word at 0 -> mem_read high for 3 cycles; resp_valid at N+4 with 0x03020100.
  - req_valid held high throughout is not re-accepted until req_ready returns.
- Reset during the RD of a store half at 16:
  - Expect immediate req_ready=1 and mem_read=0, no mem_write, no resp_valid.
  - Subsequent load word at 16 -> 0x13121110.
